// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if
// Bundles the ADC pins and the sample output bus of adc_spi_reader.
//   o_adc_cnv   : conversion start to the ADC, active high
//   o_adc_sck   : serial clock to the ADC, idles low
//   i_adc_sdo   : serial data from the ADC, MSB first
//   o_adc_data  : last captured sample, 24-bit two's complement
//   o_adc_valid : one-clock strobe, o_adc_data updated
// Modports: master = the reader, slave = ADC + downstream consumer.
`timescale 1ns/1ps
interface adc_spi_reader_if;
    logic        o_adc_cnv;
    logic        o_adc_sck;
    logic        i_adc_sdo;
    logic [23:0] o_adc_data;
    logic        o_adc_valid;

    modport master (
        output o_adc_cnv, o_adc_sck, o_adc_data, o_adc_valid,
        input  i_adc_sdo
    );

    modport slave (
        input  o_adc_cnv, o_adc_sck, o_adc_data, o_adc_valid,
        output i_adc_sdo
    );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
// Periodically starts a conversion on a 24-bit serial SAR ADC, clocks the
// result out MSB first and presents it as a 24-bit two's-complement sample
// with a one-clock valid strobe.
// Ports:
//   i_clk        : system clock
//   i_rst        : asynchronous active-low reset
//   i_en         : enable periodic sampling
//   i_test_mode  : (ADC_TEST_PATTERN_EN only) load samples from a counter
//   adc          : adc_spi_reader_if.master (cnv, sck, sdo, data, valid)
//   o_busy       : high whenever the FSM is not IDLE
//   o_skip       : one-clock pulse when a trigger arrives while busy
// Optional feature: define ADC_TEST_PATTERN_EN to add i_test_mode and an
// incrementing test-pattern source for o_adc_data.
//
// state | meaning
// IDLE  | waiting for a period trigger
// CONV  | CNV high for CONV_CYCLES cycles
// ACQ   | 24 SCK periods, SDO captured at the end of each low phase
// DONE  | one cycle, sample presented with valid
`timescale 1ns/1ps
module adc_spi_reader #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 100,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
`ifdef ADC_TEST_PATTERN_EN
    input  logic i_test_mode,
`endif
    adc_spi_reader_if.master adc,
    output logic o_busy,
    output logic o_skip
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_ACQ  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int TW = $clog2(TMAX + 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   data_q, data_d;
    logic          cnv_q, cnv_d;
    logic          sck_q, sck_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          skip_q, skip_d;
    logic          trigger;
`ifdef ADC_TEST_PATTERN_EN
    logic [23:0]   pat_q, pat_d;
`endif

    always_comb begin
        trigger  = i_en && (period_q == '0);
        period_d = '0;
        if (i_en && (period_q != PW'(SAMPLE_PERIOD - 1))) begin
            period_d = period_q + 1'b1;
        end

        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnv_d   = cnv_q;
        sck_d   = sck_q;
        valid_d = 1'b0;
        skip_d  = trigger && (state_q != ST_IDLE);
`ifdef ADC_TEST_PATTERN_EN
        pat_d   = pat_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_CONV;
                    cnv_d   = 1'b1;
                    timer_d = TW'(CONV_CYCLES - 1);
                end
            end
            ST_CONV: begin
                if (timer_q == '0) begin
                    state_d = ST_ACQ;
                    cnv_d   = 1'b0;
                    timer_d = TW'(CLK_DIV - 1);
                    bit_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ACQ: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    timer_d = TW'(CLK_DIV - 1);
                    if (!sck_q) begin
                        // end of low phase: capture the bit as SCK goes high
                        sck_d   = 1'b1;
                        shift_d = {shift_q[22:0], adc.i_adc_sdo};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 5'd23) begin
                            // valid is registered, so it is seen during DONE
                            state_d = ST_DONE;
                            valid_d = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
                            if (i_test_mode) begin
                                data_d = pat_q;
                                pat_d  = pat_q + 1'b1;
                            end else begin
                                data_d = shift_q;
                            end
`else
                            data_d = shift_q;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            cnv_q    <= 1'b0;
            sck_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            skip_q   <= 1'b0;
`ifdef ADC_TEST_PATTERN_EN
            pat_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            cnv_q    <= cnv_d;
            sck_q    <= sck_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            skip_q   <= skip_d;
`ifdef ADC_TEST_PATTERN_EN
            pat_q    <= pat_d;
`endif
        end
    end

    assign adc.o_adc_cnv   = cnv_q;
    assign adc.o_adc_sck   = sck_q;
    assign adc.o_adc_data  = data_q;
    assign adc.o_adc_valid = valid_q;
    assign o_busy          = busy_q;
    assign o_skip          = skip_q;
endmodule
